mips_muldiv_unit: RTL and testbench

// - Multi-cycle MULT/MULTU/DIV/DIVU engine that consumes the two ALU operands (rs, rt) and owns the HI/LO registers.
// - Downstream consumer of the operand path; sits beside the ALU in the execute stage.
// - CPU control FSM pulses start, stalls while busy, then reads hi/lo (MFHI/MFLO) or writes them (MTHI/MTLO).
// - Iterative: one shift-add / shift-subtract step per clock.

---
 rtl/mips_muldiv_pkg.sv | 27 ++
 rtl/mips_muldiv_unit.sv | 137 +++++++++++++
 tb/tb_mips_muldiv_unit.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mips_muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit and the decoder that drives it.
package mips_muldiv_pkg;

    typedef enum logic [5:0] {
        MULT  = 6'b011000,
        MULTU = 6'b011001,
        DIV   = 6'b011010,
        DIVU  = 6'b011011
    } muldiv_funct_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } muldiv_state_t;

    localparam logic [5:0] FUNCT_MFHI = 6'b010000;
    localparam logic [5:0] FUNCT_MTHI = 6'b010001;
    localparam logic [5:0] FUNCT_MFLO = 6'b010010;
    localparam logic [5:0] FUNCT_MTLO = 6'b010011;

    // All four multiply/divide codes share the 0110xx prefix.
    function automatic logic is_muldiv(input logic [5:0] f);
        return (f[5:2] == 4'b0110);
    endfunction

endpackage

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning HI/LO: one shift-add or
// restoring shift-subtract step per clock, with sign correction in a final FIX cycle.
module mips_muldiv_unit
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             write_hi,
    input  logic             write_lo,
    input  logic [WIDTH-1:0] write_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    muldiv_state_t     state, state_next;
    logic [CW-1:0]     count;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]  opnd;
    logic [WIDTH-1:0]  saved_a;
    logic              is_div_q;
    logic              a_neg_q;
    logic              b_neg_q;

    logic              start_ok;
    logic              start_signed;
    logic              start_div;
    logic              start_a_neg;
    logic              start_b_neg;
    logic [WIDTH-1:0]  a_mag;
    logic [WIDTH-1:0]  b_mag;

    logic [WIDTH:0]    sum;
    logic [WIDTH:0]    diff;
    logic [2*WIDTH-1:0] mul_step;
    logic [2*WIDTH-1:0] div_step;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]  fix_hi;
    logic [WIDTH-1:0]  fix_lo;

    assign busy = (state != IDLE);

    always_comb begin
        state_next   = state;
        start_ok     = start && is_muldiv(funct);
        start_signed = (funct == MULT) || (funct == DIV);
        start_div    = (funct == DIV) || (funct == DIVU);
        start_a_neg  = start_signed && op_a[WIDTH-1];
        start_b_neg  = start_signed && op_b[WIDTH-1];
        a_mag        = start_a_neg ? -op_a : op_a;
        b_mag        = start_b_neg ? -op_b : op_b;

        // Multiply: add multiplicand into the upper half when the multiplier LSB is set, then shift right.
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
        mul_step = {sum, acc[WIDTH-1:1]};

        // Divide: shift the partial remainder left and keep the subtraction only if it did not go negative.
        diff     = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
        div_step = diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                               : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

        product = (a_neg_q ^ b_neg_q) ? -acc : acc;
        fix_hi  = product[2*WIDTH-1:WIDTH];
        fix_lo  = product[WIDTH-1:0];
        if (is_div_q) begin
            if (opnd == '0) begin
                fix_hi = saved_a;
                fix_lo = '1;
            end else begin
                fix_lo = (a_neg_q ^ b_neg_q) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                fix_hi = a_neg_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
            end
        end

        unique case (state)
            IDLE:    if (start_ok) state_next = CALC;
            CALC:    if (count == CW'(WIDTH - 1)) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            acc      <= '0;
            opnd     <= '0;
            saved_a  <= '0;
            is_div_q <= 1'b0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start_ok) begin
                        count    <= '0;
                        saved_a  <= op_a;
                        is_div_q <= start_div;
                        a_neg_q  <= start_a_neg;
                        b_neg_q  <= start_b_neg;
                        opnd     <= start_div ? b_mag : a_mag;
                        acc      <= {{WIDTH{1'b0}}, (start_div ? a_mag : b_mag)};
                    end else if (!start) begin
                        if (write_hi) hi <= write_data;
                        if (write_lo) lo <= write_data;
                    end
                end
                CALC: begin
                    acc   <= is_div_q ? div_step : mul_step;
                    count <= count + 1'b1;
                end
                FIX: begin
                    hi   <= fix_hi;
                    lo   <= fix_lo;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed and randomized bench for mips_muldiv_unit against a 64-bit arithmetic model of HI/LO.
module tb_mips_muldiv_unit;
    import mips_muldiv_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [5:0]  funct;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        write_hi;
    logic        write_lo;
    logic [31:0] write_data;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    mips_muldiv_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .funct      (funct),
        .op_a       (op_a),
        .op_b       (op_b),
        .write_hi   (write_hi),
        .write_lo   (write_lo),
        .write_data (write_data),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Architectural result of one operation, straight from signed/unsigned 64-bit arithmetic.
    task automatic modelOp(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = '0;
        case (f)
            MULTU: p = {32'b0, a} * {32'b0, b};
            MULT:  p = sa * sb;
            DIVU:  if (b == 0) p = {a, 32'hFFFF_FFFF};
                   else        p = {a % b, a / b};
            DIV: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: p = {model_hi, model_lo};
        endcase
        model_hi = p[63:32];
        model_lo = p[31:0];
    endtask

    // Called at a negedge; holds start for exactly one rising edge.
    task automatic applyStimulus(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        funct = f;
        op_a  = a;
        op_b  = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int already);
        int edges;
        edges = already;
        while (done !== 1'b1 && edges < 80) begin
            @(negedge clk);
            edges++;
        end
        checkOutput({tag, " latency"}, 64'(edges), 64'd33);
        checkOutput({tag, " busy in done cycle"}, 64'(busy), 64'd0);
        checkOutput({tag, " hi"}, 64'(hi), 64'(model_hi));
        checkOutput({tag, " lo"}, 64'(lo), 64'(model_lo));
    endtask

    task automatic doOp(input string tag, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        modelOp(f, a, b);
        applyStimulus(f, a, b);
        checkOutput({tag, " busy after start"}, 64'(busy), 64'd1);
        checkOutput({tag, " done cleared"}, 64'(done), 64'd0);
        waitDone(tag, 0);
    endtask

    initial begin
        logic [31:0] prev_hi;
        logic [31:0] prev_lo;
        logic        saw_done;
        logic [5:0]  ops [4];
        logic [31:0] ra;
        logic [31:0] rb;

        ops[0] = MULT; ops[1] = MULTU; ops[2] = DIV; ops[3] = DIVU;
        reset = 1'b1; start = 1'b0; funct = '0; op_a = '0; op_b = '0;
        write_hi = 1'b0; write_lo = 1'b0; write_data = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        checkOutput("reset hi", 64'(hi), 64'd0);
        checkOutput("reset lo", 64'(lo), 64'd0);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);

        write_hi = 1'b1; write_data = 32'h1234;
        @(negedge clk);
        write_hi = 1'b0;
        model_hi = 32'h1234;
        checkOutput("mthi hi", 64'(hi), 64'(model_hi));
        checkOutput("mthi lo untouched", 64'(lo), 64'(model_lo));
        checkOutput("mthi no done", 64'(done), 64'd0);

        write_hi = 1'b1; write_lo = 1'b1; write_data = 32'hA5A5_0F0F;
        @(negedge clk);
        write_hi = 1'b0; write_lo = 1'b0;
        model_hi = 32'hA5A5_0F0F; model_lo = 32'hA5A5_0F0F;
        checkOutput("mthi+mtlo hi", 64'(hi), 64'(model_hi));
        checkOutput("mthi+mtlo lo", 64'(lo), 64'(model_lo));

        doOp("multu max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checkOutput("multu max hi const", 64'(hi), 64'h0000_0000_FFFF_FFFE);
        checkOutput("multu max lo const", 64'(lo), 64'h0000_0000_0000_0001);
        doOp("mult -3*7", MULT, 32'hFFFF_FFFD, 32'd7);
        checkOutput("mult -3*7 lo const", 64'(lo), 64'h0000_0000_FFFF_FFEB);
        doOp("divu 100/7", DIVU, 32'd100, 32'd7);
        checkOutput("divu 100/7 lo const", 64'(lo), 64'd14);
        checkOutput("divu 100/7 hi const", 64'(hi), 64'd2);
        doOp("div -7/2", DIV, 32'hFFFF_FFF9, 32'd2);
        checkOutput("div -7/2 lo const", 64'(lo), 64'h0000_0000_FFFF_FFFD);
        checkOutput("div -7/2 hi const", 64'(hi), 64'h0000_0000_FFFF_FFFF);
        doOp("divu 5/0", DIVU, 32'd5, 32'd0);
        doOp("div -5/0", DIV, 32'hFFFF_FFFB, 32'd0);
        doOp("div min/-1", DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        checkOutput("div min/-1 lo const", 64'(lo), 64'h0000_0000_8000_0000);
        doOp("mult min*min", MULT, 32'h8000_0000, 32'h8000_0000);

        // Second start during CALC and an MTLO during CALC must both be ignored.
        prev_hi = model_hi; prev_lo = model_lo;
        applyStimulus(MULT, 32'hFFFF_FF85, 32'd1000);
        repeat (4) @(negedge clk);
        start = 1'b1; funct = MULTU; op_a = 32'd3; op_b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        write_lo = 1'b1; write_data = 32'hBEEF;
        @(negedge clk);
        write_lo = 1'b0;
        checkOutput("calc hi held", 64'(hi), 64'(prev_hi));
        checkOutput("calc mtlo ignored", 64'(lo), 64'(prev_lo));
        checkOutput("calc still busy", 64'(busy), 64'd1);
        modelOp(MULT, 32'hFFFF_FF85, 32'd1000);
        waitDone("restart ignored", 6);

        // MTHI in the same cycle as start: the operation wins.
        prev_hi = model_hi;
        start = 1'b1; funct = DIVU; op_a = 32'd1000; op_b = 32'd33;
        write_hi = 1'b1; write_data = 32'hDEAD;
        @(negedge clk);
        start = 1'b0; write_hi = 1'b0;
        checkOutput("start+mthi busy", 64'(busy), 64'd1);
        checkOutput("start+mthi hi unwritten", 64'(hi), 64'(prev_hi));
        modelOp(DIVU, 32'd1000, 32'd33);
        waitDone("start+mthi", 0);

        // Start with a non-muldiv funct: nothing runs, and the strobe is still blocked.
        start = 1'b1; funct = FUNCT_MFHI; write_lo = 1'b1; write_data = 32'h55;
        @(negedge clk);
        start = 1'b0; write_lo = 1'b0;
        checkOutput("bad funct busy", 64'(busy), 64'd0);
        checkOutput("bad funct lo", 64'(lo), 64'(model_lo));

        // Reset partway through a divide.
        applyStimulus(DIV, 32'h7654_3210, 32'hFFFF_0003);
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_hi = '0; model_lo = '0;
        checkOutput("abort busy", 64'(busy), 64'd0);
        checkOutput("abort hi", 64'(hi), 64'd0);
        checkOutput("abort lo", 64'(lo), 64'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        checkOutput("abort no done", 64'(saw_done), 64'd0);

        // Random operations, issued back to back from each done cycle.
        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = $urandom;
            if ((i % 5) == 1) rb = $urandom_range(1, 15);
            if ((i % 5) == 2) rb = 32'hFFFF_FFFF - $urandom_range(0, 7);
            if ((i % 7) == 3) rb = '0;
            doOp($sformatf("rand%0d", i), ops[$urandom_range(0, 3)], ra, rb);
        end

        @(negedge clk);
        checkOutput("final done pulse ends", 64'(done), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
